// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: stage k ripples slice k, operands skewed in and result slices deskewed out; latency STAGES, 1 beat/cycle.
// One global advance (~out_valid | out_ready) holds every register on stall. Optional ovf output: define PCA_OVERFLOW_EN.
module pipelined_carry_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic w_advance;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still to be added when slice k is processed: slices k..STAGES-1.
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         w_a_in;
    logic [REM-1:0]         w_b_in;
    logic                   w_vld_in;
    logic                   w_cy_in;
    logic [(k+1)*CHUNK-1:0] w_sum_nxt;
    logic [CHUNK:0]         w_add;
    logic                   r_vld;
    logic                   r_cy;
    logic [(k+1)*CHUNK-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a_in    = a;
      assign w_b_in    = b ^ {WIDTH{sub}};
      assign w_vld_in  = in_valid;
      assign w_cy_in   = sub | c_in;
      assign w_sum_nxt = w_add[CHUNK-1:0];
    end else begin : g_src
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= g_stg[k-1].w_a_in[REM+CHUNK-1:CHUNK];
          r_b <= g_stg[k-1].w_b_in[REM+CHUNK-1:CHUNK];
        end
      end

      assign w_a_in    = r_a;
      assign w_b_in    = r_b;
      assign w_vld_in  = g_stg[k-1].r_vld;
      assign w_cy_in   = g_stg[k-1].r_cy;
      assign w_sum_nxt = {w_add[CHUNK-1:0], g_stg[k-1].r_sum};
    end

    assign w_add = {1'b0, w_a_in[CHUNK-1:0]} + {1'b0, w_b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_cy_in};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_vld <= w_vld_in;
        r_cy  <= w_add[CHUNK];
        r_sum <= w_sum_nxt;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_vld;
  assign c_out     = g_stg[STAGES-1].r_cy;
  assign sum       = g_stg[STAGES-1].r_sum;

`ifdef PCA_OVERFLOW_EN
  logic w_ovf_nxt;
  logic r_ovf;

  // Carry into the MSB is recovered as a ^ b' ^ s at that bit.
  assign w_ovf_nxt = g_stg[STAGES-1].w_add[CHUNK]
                   ^ g_stg[STAGES-1].w_a_in[CHUNK-1]
                   ^ g_stg[STAGES-1].w_b_in[CHUNK-1]
                   ^ g_stg[STAGES-1].w_add[CHUNK-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
